// File: rtl/add_round_key_stage.sv
// add_round_key_stage: AES AddRoundKey pipeline stage with valid/ready handshake and round-key index sequencing.
module add_round_key_stage #(
  parameter int word_size  = 8,
  parameter int array_size = 16,
  parameter int NR         = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           restart,
  input  logic [word_size*array_size-1:0] state,
  input  logic [word_size*array_size-1:0] round_key,
  input  logic                           out_ready,
  output logic                           in_ready,
  output logic [3:0]                     key_idx,
  output logic [word_size*array_size-1:0] state_out,
  output logic                           done,
  output logic [3:0]                     round,
  output logic                           last
);
  localparam int W = word_size * array_size;
  logic         accept;
  logic [W-1:0] state_d, state_q;
  logic [3:0]   key_d, key_q, round_d, round_q;
  logic         done_d, done_q, last_d, last_q;
  assign in_ready = (!done_q || out_ready) && !restart;
  assign accept   = enable && in_ready;
  always_comb begin
    state_d = accept ? state ^ round_key : state_q;
    round_d = accept ? key_q : round_q;
    last_d  = accept ? (key_q == 4'(NR)) : last_q;
    done_d  = accept ? 1'b1 : (out_ready ? 1'b0 : done_q);
    key_d   = restart ? 4'd0 : (accept ? (key_q == 4'(NR) ? 4'd0 : key_q + 4'd1) : key_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      round_q <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      last_q  <= last_d;
      done_q  <= done_d;
      key_q   <= key_d;
    end
  end
  assign state_out = state_q;
  assign round     = round_q;
  assign last      = last_q;
  assign done      = done_q;
  assign key_idx   = key_q;
endmodule

// File: doc/add_round_key_stage.md
ADD_ROUND_KEY_STAGE -- requirements
Module: add_round_key_stage

Interface
REQ-001 Parameter word_size, default 8, SHALL set the byte width.
REQ-002 Parameter array_size, default 16, SHALL set the bytes per state; state width = word_size*array_size (128).
REQ-003 Parameter NR, default 10, SHALL set the last round index; valid round indices are 0..NR.
REQ-004 clk  input  1  SHALL be the single clock; all flops update on its rising edge.
REQ-005 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-006 enable  input  1  SHALL be input valid: the state word is offered this cycle.
REQ-007 restart  input  1  SHALL, when high, resynchronise the round counter to 0.
REQ-008 state  input  128  SHALL carry the state, typically the MixColumns result.
REQ-009 round_key  input  128  SHALL carry the round key for index key_idx, returned combinationally by the key store in the same cycle.
REQ-010 out_ready  input  1  SHALL indicate the downstream stage accepts state_out this cycle.
REQ-011 in_ready  output  1  SHALL indicate this stage accepts state this cycle.
REQ-012 key_idx  output  4  SHALL be the registered round index requested from the key store.
REQ-013 state_out  output  128  SHALL be the registered result.
REQ-014 done  output  1  SHALL be output valid: state_out is held valid.
REQ-015 round  output  4  SHALL be the round index applied to the current state_out.
REQ-016 last  output  1  SHALL be high when the current state_out is the final round (round == NR).

Function
REQ-017 in_ready SHALL equal (!done || out_ready) && !restart, combinationally.
REQ-018 Accept SHALL occur on a cycle with enable && in_ready.
REQ-019 On accept: state_out <= state XOR round_key (bitwise, all 128 bits); done <= 1; round <= key_idx; last <= (key_idx == NR).
REQ-020 On accept: key_idx SHALL become 0 if key_idx == NR, else key_idx+1 (wrap after NR).
REQ-021 Latency SHALL be exactly 1 cycle from accept to done high with the result.
REQ-022 Throughput SHALL be one block per cycle when out_ready stays high.
REQ-023 Hold: if done && !out_ready, state_out, round, last and done SHALL stay unchanged and nothing is accepted.
REQ-024 Drain: if done && out_ready and no accept, done SHALL go to 0 next cycle; state_out, round and last keep their values.
REQ-025 Simultaneous drain and accept: the new result SHALL replace the old one, and done SHALL stay 1 with no bubble.
REQ-026 restart SHALL set key_idx <= 0 next cycle and block accept that cycle; done, state_out, round and last are unaffected, so pending output still drains normally.
REQ-027 If restart is asserted while key_idx is already 0, the stage SHALL simply stall input for that cycle.
REQ-028 enable without in_ready SHALL have no effect; the upstream stage holds its data.
REQ-029 No output SHALL change on cycles with no accept, drain, restart or reset.

Reset
REQ-030 While rst is high at a clock edge: state_out <= 0, done <= 0, round <= 0, last <= 0, key_idx <= 0.
REQ-031 rst SHALL take priority over enable, restart and out_ready.
REQ-032 Reset mid-block SHALL discard the pending result and the round position; the next accept uses key_idx 0.
REQ-033 in_ready SHALL be 1 in the first cycle after reset when restart is low.

Verification
REQ-034 FIPS-197 test: state=00112233445566778899aabbccddeeff, round_key=000102030405060708090a0b0c0d0e0f, enable=1, out_ready=1 -> next cycle done=1, state_out=00102030405060708090a0b0c0d0e0f0, round=0, last=0, key_idx=1.
REQ-035 Send 11 back-to-back accepts with out_ready=1 -> round goes 0..10, last=1 only on the 11th, then key_idx=0; no bubbles in done.
REQ-036 Backpressure: accept block A, hold out_ready=0 for 3 cycles with enable=1 -> in_ready=0 and state_out=A stable; raise out_ready -> B accepted in the same cycle A drains.
REQ-037 Assert restart at key_idx=5 with enable=1 -> no accept that cycle, key_idx=0 next cycle, and the pending output is unaffected.
REQ-038 Assert rst while done=1 and key_idx=7 -> all outputs and key_idx are 0 next cycle, and in_ready=1.
